tensor_block_seq: RTL and testbench
===================================

# tensor_block_seq

Sequencer and input arbiter for one `tensor_block` (int8, 3 dot units × 10 lanes, 32-bit accumulators). It accepts one ordered 80-bit stream carrying both weight beats and activation beats, and buffers activations in an internal FIFO. It drives every `tensor_block` control pin so that each pass of K activation chunks is issued on consecutive cycles and accumulated into `acc0..2`. It pulses `res_valid` in the cycle the tensor block's `out0..2`/`acc*_out` hold the final pass result.

## Interface
Parameters:
- `ACT_DEPTH`, 8: activation FIFO entries; also the maximum K.
- `CNT_W`, 4: width of `cfg_k` and the internal counters; must hold `ACT_DEPTH`.

Ports:
- `clk` in 1: clock.
- `reset` in 1: reset, asynchronous, active-high.
- `cfg_k` in CNT_W: chunks per pass. Clamped to 1..ACT_DEPTH, so 0 counts as 1. Latched at pass start.
- `cfg_wsrc_cascade` in 1: 1 = weights are taken from the tensor block `cascade_in`; the `s_data` of weight beats is ignored.
- `s_valid` / `s_ready` in/out 1: input stream handshake.
- `s_data` in 80: beat payload.
- `s_is_weight` in 1: 1 = weight beat. Weight beats come in groups of 3; the row that ends up in `bank0_reg2` is sent first.
- `tb_data_in` out 80: drives tensor block `data_in`.
- `tb_mux1_select`, `tb_dot_unit_input_1_enable`, `tb_bank0_data_in_enable` out 1: tensor block controls.
- `tb_bank1_data_in_enable`, `tb_cascade_out_select`, `tb_dot_unit_input_2_select` out 1: tied to 0. Only bank0 is used.
- `tb_accumulator_input1_select` out 3: accumulator feedback select.
- `res_valid` out 1: one-cycle pulse marking the final pass result. There is no backpressure; the consumer must capture the result in that cycle.
- `busy` out 1: high when the FSM is not in IDLE, or the FIFO is non-empty, or a pipeline tag is live.

## Operation
- FIFO: holds activation beats only. Push = accepted activation beat. Pop = one issue in RUN. Push and pop in the same cycle are allowed.
- `s_ready`:
  - Activation beat: FIFO not full. There is no pop-through when full.
  - Weight beat: state is WLOAD, or state is IDLE with the FIFO empty.
  - Stream order is preserved: a stalled head beat blocks everything behind it.
- States:
  - IDLE:
    - If FIFO count ≥ k_eff, go to RUN with that k_eff.
    - Otherwise, if the head beat is a weight and the FIFO is non-empty, flush: go to RUN with k = count (short pass).
    - Otherwise, if an accepted weight beat arrives with the FIFO empty, go to WLOAD with the weight counter at 1.
  - WLOAD:
    - `tb_bank0_data_in_enable` = accepted weight beat.
    - After the 3rd beat, go to IDLE.
    - An activation at the head stalls until the 3 weight beats are complete.
  - RUN, one issue per cycle:
    - `tb_data_in` = FIFO head; `tb_dot_unit_input_1_enable` = 1; pop.
    - Issue index runs 0..k-1.
    - After the last issue: if the post-pop count (including any same-cycle push) ≥ the current clamped `cfg_k`, stay in RUN for a new pass starting next cycle. Otherwise go to IDLE.
- `tb_data_in`: `s_data` in IDLE/WLOAD, FIFO head in RUN.
- `tb_mux1_select` = `cfg_wsrc_cascade` when `tb_bank0_data_in_enable` is 1, else 0.
- Tag pipeline: 2 stages carrying {valid, first, last}, loaded at each issue.
  - At stage 2 (issue cycle + 2): `tb_accumulator_input1_select` = 3'b000 if first (adds `acc*_in`), 3'b111 otherwise.
  - With no valid tag, select = 3'b000.
  - `res_valid` = valid & last at stage 2.
- Arithmetic: all width handling is in the tensor block. The controller only counts. `acc*_in` must be 0 when no chaining is wanted.

## Timing
- Reset values:
  - FIFO empty; state IDLE; tags cleared.
  - `s_ready`=0 while reset is asserted.
  - All `tb_*` enables and selects = 0; `tb_data_in` = 0.
  - `res_valid` = 0; `busy` = 0.
- First issue: earliest in the cycle after the beat that makes count ≥ k is accepted.
- Result: `res_valid` in (last issue cycle + 2). Pass latency is k + 2 cycles from the first issue.
- Back-to-back passes have no bubble. The first tag forces select 000 exactly at the pass boundary.
- A weight load may begin in the cycle after the last issue. The bank is not disturbed before the in-flight dot product is flopped.
- `cfg_k` changes mid-pass take effect at the next pass start.
- Reset mid-operation: immediate return to the reset state. Any partial pass is discarded and no `res_valid` is emitted. The tensor block is reset by the same `reset`.

## Test plan
- Weight and data check:
  - Stimulus: 3 weight beats of all bytes 0x02, k=2, two activations of all bytes 0x01, `acc0_in`=0.
  - Response: selects 000 then 111 at issue+2; `res_valid` at issue1+2; `acc0_out` = 40; `out0` = 0 (40 >> 7).
- Back-to-back k=1:
  - Stimulus: 4 consecutive activations.
  - Response: 4 consecutive issues; `res_valid` high for 4 cycles; select 000 every cycle.
- Flush:
  - Stimulus: k=4, 2 activations, then a weight beat.
  - Response: short pass of 2 issues; weight accepted the cycle after IDLE; `res_valid` after issue 2.
- Backpressure:
  - Stimulus: ACT_DEPTH=8, k=8, 9 activations presented with no prior weight load.
  - Response: the 9th beat's `s_ready`=0 until the first RUN pop; 8 issues in consecutive cycles.
- Cascade source:
  - Stimulus: `cfg_wsrc_cascade`=1, 3 weight beats.
  - Response: `tb_mux1_select`=1 exactly during the 3 bank enables.
- Reset mid-RUN:
  - Stimulus: assert `reset` during issue 3 of a k=6 pass.
  - Response: all outputs return to reset values; no `res_valid`; `busy`=0.

Source files
------------

// File: rtl/tensor_block_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tensor_block_seq
//  Description : Sequencer and input arbiter for one int8 tensor_block.
//                Splits an ordered 80-bit stream into bank0 weight loads and
//                buffered activation chunks, issues passes of K chunks on
//                consecutive cycles and flags the final accumulated result.
//  Revision    : 1.0 - initial release
// ============================================================================
module tensor_block_seq #(
    parameter int ACT_DEPTH = 8,
    parameter int CNT_W     = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] cfg_k,
    input  logic             cfg_wsrc_cascade,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [79:0]      s_data,
    input  logic             s_is_weight,
    output logic [79:0]      tb_data_in,
    output logic             tb_mux1_select,
    output logic             tb_dot_unit_input_1_enable,
    output logic             tb_bank0_data_in_enable,
    output logic             tb_bank1_data_in_enable,
    output logic             tb_cascade_out_select,
    output logic             tb_dot_unit_input_2_select,
    output logic [2:0]       tb_accumulator_input1_select,
    output logic             res_valid,
    output logic             busy
);

    localparam int               PTR_W      = (ACT_DEPTH > 1) ? $clog2(ACT_DEPTH) : 1;
    localparam logic [CNT_W-1:0] C_DEPTH    = CNT_W'(ACT_DEPTH);
    localparam logic [PTR_W-1:0] C_LAST_PTR = PTR_W'(ACT_DEPTH - 1);
    localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WLOAD = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    // Activation FIFO storage and bookkeeping
    logic [79:0]      r_mem [ACT_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    // Pass / weight-load counters
    logic [CNT_W-1:0] r_k_pass;
    logic [CNT_W-1:0] r_issue_idx;
    logic [1:0]       r_wcnt;

    // Two-stage tag pipeline {valid, first, last}
    logic             r_tag1_valid;
    logic             r_tag1_first;
    logic             r_tag1_last;
    logic             r_tag2_valid;
    logic             r_tag2_first;
    logic             r_tag2_last;

    logic [CNT_W-1:0] w_k_eff;
    logic             w_fifo_empty;
    logic             w_fifo_full;
    logic             w_ready;
    logic             w_accept;
    logic             w_push;
    logic             w_wbeat;
    logic             w_pop;
    logic [CNT_W-1:0] w_count_next;
    logic             w_last_issue;
    logic             w_pass_start;
    logic [CNT_W-1:0] w_pass_k;

    // Clamp the requested chunk count into 1..ACT_DEPTH
    always_comb begin
        w_k_eff = cfg_k;
        if (cfg_k == '0) begin
            w_k_eff = C_ONE;
        end else if (cfg_k > C_DEPTH) begin
            w_k_eff = C_DEPTH;
        end
    end

    assign w_fifo_empty = (r_count == '0);
    assign w_fifo_full  = (r_count == C_DEPTH);

    // Head-of-stream acceptance: weights only when the bank is free to load,
    // activations only when the FIFO has room and no weight group is open
    always_comb begin
        w_ready = 1'b0;
        if (!reset) begin
            if (s_is_weight) begin
                w_ready = (r_state == S_WLOAD) ||
                          ((r_state == S_IDLE) && w_fifo_empty);
            end else begin
                w_ready = !w_fifo_full && (r_state != S_WLOAD);
            end
        end
    end

    assign w_accept     = s_valid & w_ready;
    assign w_push       = w_accept & ~s_is_weight;
    assign w_wbeat      = w_accept & s_is_weight;
    assign w_pop        = (r_state == S_RUN);
    assign w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    assign w_last_issue = w_pop && (r_issue_idx == (r_k_pass - C_ONE));

    // Next-state decode; also selects the K latched for a starting pass
    always_comb begin
        w_state_next = r_state;
        w_pass_start = 1'b0;
        w_pass_k     = r_k_pass;
        case (r_state)
            S_IDLE: begin
                if (w_count_next >= w_k_eff) begin
                    w_state_next = S_RUN;
                    w_pass_start = 1'b1;
                    w_pass_k     = w_k_eff;
                end else if (s_valid && s_is_weight && !w_fifo_empty) begin
                    // Weight waiting behind a partial batch: flush it as a short pass
                    w_state_next = S_RUN;
                    w_pass_start = 1'b1;
                    w_pass_k     = r_count;
                end else if (w_wbeat) begin
                    w_state_next = S_WLOAD;
                end
            end
            S_WLOAD: begin
                if (w_wbeat && (r_wcnt == 2'd2)) begin
                    w_state_next = S_IDLE;
                end
            end
            S_RUN: begin
                if (w_last_issue) begin
                    if (w_count_next >= w_k_eff) begin
                        w_pass_start = 1'b1;
                        w_pass_k     = w_k_eff;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FIFO payload write; contents are don't-care while empty
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= s_data;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == C_LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == C_LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
            end
            r_count <= w_count_next;
        end
    end

    // Pass length, issue index and weight-beat counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_k_pass    <= C_ONE;
            r_issue_idx <= '0;
            r_wcnt      <= 2'd0;
        end else begin
            if (w_pass_start) begin
                r_k_pass    <= w_pass_k;
                r_issue_idx <= '0;
            end else if (w_pop) begin
                r_issue_idx <= r_issue_idx + C_ONE;
            end
            if (w_wbeat) begin
                r_wcnt <= (r_state == S_IDLE) ? 2'd1 : r_wcnt + 2'd1;
            end
        end
    end

    // Tag pipeline aligning accumulator control with the dot-product latency
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tag1_valid <= 1'b0;
            r_tag1_first <= 1'b0;
            r_tag1_last  <= 1'b0;
            r_tag2_valid <= 1'b0;
            r_tag2_first <= 1'b0;
            r_tag2_last  <= 1'b0;
        end else begin
            r_tag1_valid <= w_pop;
            r_tag1_first <= w_pop && (r_issue_idx == '0);
            r_tag1_last  <= w_last_issue;
            r_tag2_valid <= r_tag1_valid;
            r_tag2_first <= r_tag1_first;
            r_tag2_last  <= r_tag1_last;
        end
    end

    // Tensor block drive: stream passes straight through except while issuing
    always_comb begin
        tb_data_in = 80'd0;
        if (!reset) begin
            tb_data_in = (r_state == S_RUN) ? r_mem[r_rd_ptr] : s_data;
        end
    end

    assign s_ready                      = w_ready;
    assign tb_bank0_data_in_enable      = w_wbeat;
    assign tb_mux1_select               = w_wbeat & cfg_wsrc_cascade;
    assign tb_dot_unit_input_1_enable   = w_pop;
    assign tb_bank1_data_in_enable      = 1'b0;
    assign tb_cascade_out_select        = 1'b0;
    assign tb_dot_unit_input_2_select   = 1'b0;
    // First chunk of a pass adds acc*_in; later chunks feed back the accumulator
    assign tb_accumulator_input1_select = (r_tag2_valid && !r_tag2_first) ? 3'b111 : 3'b000;
    assign res_valid                    = r_tag2_valid & r_tag2_last;
    assign busy                         = (r_state != S_IDLE) || !w_fifo_empty ||
                                          r_tag1_valid || r_tag2_valid;

endmodule
`default_nettype wire

// File: tb/tb_tensor_block_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tensor_block_seq
//  Description : Directed self-checking bench for tensor_block_seq.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tensor_block_seq;

    logic        clk;
    logic        reset;
    logic [3:0]  cfg_k;
    logic        cfg_wsrc_cascade;
    logic        s_valid;
    logic        s_ready;
    logic [79:0] s_data;
    logic        s_is_weight;
    logic [79:0] tb_data_in;
    logic        tb_mux1_select;
    logic        tb_dot_unit_input_1_enable;
    logic        tb_bank0_data_in_enable;
    logic        tb_bank1_data_in_enable;
    logic        tb_cascade_out_select;
    logic        tb_dot_unit_input_2_select;
    logic [2:0]  tb_accumulator_input1_select;
    logic        res_valid;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    tensor_block_seq #(
        .ACT_DEPTH (8),
        .CNT_W     (4)
    ) dut (
        .clk                          (clk),
        .reset                        (reset),
        .cfg_k                        (cfg_k),
        .cfg_wsrc_cascade             (cfg_wsrc_cascade),
        .s_valid                      (s_valid),
        .s_ready                      (s_ready),
        .s_data                       (s_data),
        .s_is_weight                  (s_is_weight),
        .tb_data_in                   (tb_data_in),
        .tb_mux1_select               (tb_mux1_select),
        .tb_dot_unit_input_1_enable   (tb_dot_unit_input_1_enable),
        .tb_bank0_data_in_enable      (tb_bank0_data_in_enable),
        .tb_bank1_data_in_enable      (tb_bank1_data_in_enable),
        .tb_cascade_out_select        (tb_cascade_out_select),
        .tb_dot_unit_input_2_select   (tb_dot_unit_input_2_select),
        .tb_accumulator_input1_select (tb_accumulator_input1_select),
        .res_valid                    (res_valid),
        .busy                         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [79:0] rep(input logic [7:0] b);
        return {10{b}};
    endfunction

    // Drive one cycle's stream inputs and let combinational outputs settle
    task automatic cyc(input logic v, input logic w, input logic [79:0] d);
        s_valid     = v;
        s_is_weight = w;
        s_data      = d;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        cyc(1'b0, 1'b0, 80'd0);
        while (busy && n < 64) begin
            step();
            n++;
        end
        check_eq("drain_busy", 80'(busy), 80'd0);
    endtask

    initial begin
        reset            = 1'b1;
        cfg_k            = 4'd2;
        cfg_wsrc_cascade = 1'b0;
        s_valid          = 1'b1;
        s_is_weight      = 1'b0;
        s_data           = rep(8'hAA);
        repeat (2) @(posedge clk);
        #2;
        // Reset state
        check_eq("rst_s_ready", 80'(s_ready), 80'd0);
        check_eq("rst_data_in", tb_data_in, 80'd0);
        check_eq("rst_dot_en", 80'(tb_dot_unit_input_1_enable), 80'd0);
        check_eq("rst_bank0", 80'(tb_bank0_data_in_enable), 80'd0);
        check_eq("rst_mux1", 80'(tb_mux1_select), 80'd0);
        check_eq("rst_sel", 80'(tb_accumulator_input1_select), 80'd0);
        check_eq("rst_res", 80'(res_valid), 80'd0);
        check_eq("rst_busy", 80'(busy), 80'd0);
        check_eq("tied_zero", 80'({tb_bank1_data_in_enable, tb_cascade_out_select,
                                   tb_dot_unit_input_2_select}), 80'd0);
        s_valid = 1'b0;
        s_data  = 80'd0;
        @(negedge clk);
        reset = 1'b0;
        step();

        // Weight load then a k=2 pass
        cyc(1'b1, 1'b1, rep(8'h02));
        check_eq("w0_ready", 80'(s_ready), 80'd1);
        check_eq("w0_bank0", 80'(tb_bank0_data_in_enable), 80'd1);
        check_eq("w0_mux1", 80'(tb_mux1_select), 80'd0);
        check_eq("w0_data", tb_data_in, rep(8'h02));
        step();
        cyc(1'b1, 1'b1, rep(8'h02));
        check_eq("w1_bank0", 80'(tb_bank0_data_in_enable), 80'd1);
        step();
        cyc(1'b1, 1'b1, rep(8'h02));
        check_eq("w2_bank0", 80'(tb_bank0_data_in_enable), 80'd1);
        step();
        cyc(1'b1, 1'b0, rep(8'h01));
        check_eq("a0_ready", 80'(s_ready), 80'd1);
        check_eq("a0_bank0", 80'(tb_bank0_data_in_enable), 80'd0);
        check_eq("a0_dot", 80'(tb_dot_unit_input_1_enable), 80'd0);
        step();
        cyc(1'b1, 1'b0, rep(8'h01));
        step();
        cyc(1'b0, 1'b0, 80'd0);
        check_eq("k2_iss0_dot", 80'(tb_dot_unit_input_1_enable), 80'd1);
        check_eq("k2_iss0_data", tb_data_in, rep(8'h01));
        step();
        check_eq("k2_iss1_dot", 80'(tb_dot_unit_input_1_enable), 80'd1);
        check_eq("k2_iss1_res", 80'(res_valid), 80'd0);
        step();
        check_eq("k2_p2_dot", 80'(tb_dot_unit_input_1_enable), 80'd0);
        check_eq("k2_p2_sel", 80'(tb_accumulator_input1_select), 80'd0);
        check_eq("k2_p2_res", 80'(res_valid), 80'd0);
        check_eq("k2_p2_busy", 80'(busy), 80'd1);
        step();
        check_eq("k2_p3_sel", 80'(tb_accumulator_input1_select), 80'd7);
        check_eq("k2_p3_res", 80'(res_valid), 80'd1);
        step();
        check_eq("k2_p4_sel", 80'(tb_accumulator_input1_select), 80'd0);
        check_eq("k2_p4_res", 80'(res_valid), 80'd0);
        check_eq("k2_p4_busy", 80'(busy), 80'd0);

        // Back-to-back k=1 passes with distinct payloads
        cfg_k = 4'd1;
        for (int c = 0; c < 7; c++) begin
            if (c < 4) cyc(1'b1, 1'b0, rep(8'(16 + c)));
            else       cyc(1'b0, 1'b0, 80'd0);
            if (c < 4) check_eq("b2b_ready", 80'(s_ready), 80'd1);
            check_eq("b2b_dot", 80'(tb_dot_unit_input_1_enable), 80'((c >= 1 && c <= 4) ? 1 : 0));
            if (c >= 1 && c <= 4) check_eq("b2b_data", tb_data_in, rep(8'(16 + c - 1)));
            check_eq("b2b_res", 80'(res_valid), 80'((c >= 3 && c <= 6) ? 1 : 0));
            check_eq("b2b_sel", 80'(tb_accumulator_input1_select), 80'd0);
            step();
        end
        drain();

        // Flush: partial batch ahead of a weight beat
        cfg_k = 4'd4;
        cyc(1'b1, 1'b0, rep(8'h21));
        step();
        cyc(1'b1, 1'b0, rep(8'h22));
        step();
        cyc(1'b1, 1'b1, rep(8'h02));
        check_eq("fl_c2_ready", 80'(s_ready), 80'd0);
        check_eq("fl_c2_dot", 80'(tb_dot_unit_input_1_enable), 80'd0);
        step();
        check_eq("fl_c3_dot", 80'(tb_dot_unit_input_1_enable), 80'd1);
        check_eq("fl_c3_data", tb_data_in, rep(8'h21));
        check_eq("fl_c3_ready", 80'(s_ready), 80'd0);
        step();
        check_eq("fl_c4_dot", 80'(tb_dot_unit_input_1_enable), 80'd1);
        check_eq("fl_c4_data", tb_data_in, rep(8'h22));
        check_eq("fl_c4_ready", 80'(s_ready), 80'd0);
        step();
        check_eq("fl_c5_ready", 80'(s_ready), 80'd1);
        check_eq("fl_c5_bank0", 80'(tb_bank0_data_in_enable), 80'd1);
        check_eq("fl_c5_dot", 80'(tb_dot_unit_input_1_enable), 80'd0);
        check_eq("fl_c5_sel", 80'(tb_accumulator_input1_select), 80'd0);
        check_eq("fl_c5_res", 80'(res_valid), 80'd0);
        step();
        check_eq("fl_c6_bank0", 80'(tb_bank0_data_in_enable), 80'd1);
        check_eq("fl_c6_res", 80'(res_valid), 80'd1);
        check_eq("fl_c6_sel", 80'(tb_accumulator_input1_select), 80'd7);
        step();
        check_eq("fl_c7_bank0", 80'(tb_bank0_data_in_enable), 80'd1);
        check_eq("fl_c7_res", 80'(res_valid), 80'd0);
        step();
        cyc(1'b0, 1'b0, 80'd0);
        check_eq("fl_c8_busy", 80'(busy), 80'd0);

        // Backpressure: 9 activations into an 8-deep FIFO with k=8
        cfg_k = 4'd8;
        for (int c = 0; c < 8; c++) begin
            cyc(1'b1, 1'b0, rep(8'(48 + c)));
            check_eq("bp_fill_ready", 80'(s_ready), 80'd1);
            check_eq("bp_fill_dot", 80'(tb_dot_unit_input_1_enable), 80'd0);
            step();
        end
        cyc(1'b1, 1'b0, rep(8'h38));
        check_eq("bp_full_ready", 80'(s_ready), 80'd0);
        check_eq("bp_iss0_dot", 80'(tb_dot_unit_input_1_enable), 80'd1);
        check_eq("bp_iss0_data", tb_data_in, rep(8'h30));
        step();
        check_eq("bp_pop_ready", 80'(s_ready), 80'd1);
        check_eq("bp_iss1_data", tb_data_in, rep(8'h31));
        step();
        for (int c = 10; c < 16; c++) begin
            cyc(1'b0, 1'b0, 80'd0);
            check_eq("bp_iss_dot", 80'(tb_dot_unit_input_1_enable), 80'd1);
            check_eq("bp_iss_data", tb_data_in, rep(8'(48 + c - 8)));
            check_eq("bp_iss_res", 80'(res_valid), 80'd0);
            step();
        end
        cfg_k = 4'd1;
        cyc(1'b0, 1'b0, 80'd0);
        check_eq("bp_c16_dot", 80'(tb_dot_unit_input_1_enable), 80'd0);
        step();
        check_eq("bp_c17_res", 80'(res_valid), 80'd1);
        check_eq("bp_c17_sel", 80'(tb_accumulator_input1_select), 80'd7);
        check_eq("bp_c17_dot", 80'(tb_dot_unit_input_1_enable), 80'd1);
        check_eq("bp_c17_data", tb_data_in, rep(8'h38));
        drain();

        // Cascade weight source
        cfg_wsrc_cascade = 1'b1;
        cyc(1'b0, 1'b0, 80'd0);
        check_eq("cas_idle_mux1", 80'(tb_mux1_select), 80'd0);
        step();
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b1, rep(8'hEE));
            check_eq("cas_mux1", 80'(tb_mux1_select), 80'd1);
            check_eq("cas_bank0", 80'(tb_bank0_data_in_enable), 80'd1);
            step();
        end
        cyc(1'b0, 1'b0, 80'd0);
        check_eq("cas_after_mux1", 80'(tb_mux1_select), 80'd0);
        check_eq("cas_after_bank0", 80'(tb_bank0_data_in_enable), 80'd0);
        cfg_wsrc_cascade = 1'b0;
        drain();

        // cfg_k = 0 behaves as 1
        cfg_k = 4'd0;
        cyc(1'b1, 1'b0, rep(8'h55));
        step();
        cyc(1'b0, 1'b0, 80'd0);
        check_eq("k0_dot", 80'(tb_dot_unit_input_1_enable), 80'd1);
        check_eq("k0_data", tb_data_in, rep(8'h55));
        drain();

        // Reset during issue 3 of a k=6 pass
        cfg_k = 4'd6;
        for (int c = 0; c < 6; c++) begin
            cyc(1'b1, 1'b0, rep(8'(96 + c)));
            step();
        end
        cyc(1'b0, 1'b0, 80'd0);
        check_eq("rr_iss0_data", tb_data_in, rep(8'h60));
        step();
        check_eq("rr_iss1_data", tb_data_in, rep(8'h61));
        step();
        cyc(1'b1, 1'b0, rep(8'h77));
        check_eq("rr_iss2_dot", 80'(tb_dot_unit_input_1_enable), 80'd1);
        check_eq("rr_iss2_data", tb_data_in, rep(8'h62));
        reset = 1'b1;
        #1;
        check_eq("rr_dot", 80'(tb_dot_unit_input_1_enable), 80'd0);
        check_eq("rr_ready", 80'(s_ready), 80'd0);
        check_eq("rr_data", tb_data_in, 80'd0);
        check_eq("rr_busy", 80'(busy), 80'd0);
        check_eq("rr_res", 80'(res_valid), 80'd0);
        check_eq("rr_sel", 80'(tb_accumulator_input1_select), 80'd0);
        step();
        s_valid = 1'b0;
        s_data  = 80'd0;
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            check_eq("rr_post_res", 80'(res_valid), 80'd0);
            check_eq("rr_post_busy", 80'(busy), 80'd0);
            check_eq("rr_post_dot", 80'(tb_dot_unit_input_1_enable), 80'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
